// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: synchronise, latch pending, arbitrate lowest index, REQ/SERVICE handshake.
// Latency: SYNC_STAGES+2 edges from the first sampling edge of an edge-mode irq_in pulse to irq_req.
// Backpressure: a request holds in REQ until irq_ack (or a mask-off); new pending bits wait while busy.
module int_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  input  logic               mode_we,
  input  logic [NUM_IRQ-1:0] mode_wd,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_nxt;
  logic [ID_W-1:0]    id_nxt, low_id;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_bit, sync_prev, rise;
  logic [NUM_IRQ-1:0] mask_q, mode_q, mode_nxt;
  logic [NUM_IRQ-1:0] active, ack_clr, sw_clr, pend_nxt;
  logic               ack_edge;

  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign rise     = sync_bit & ~sync_prev;
  assign active   = pending & mask_q;

  // Metastability chain per line, plus the previous synchronized value for rise detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      sync_prev <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      sync_prev <= sync_bit;
    end
  end

  // Lowest-index enabled pending channel wins arbitration
  always_comb begin
    low_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) low_id = ID_W'(i);
    end
  end

  // Next-state logic; a mask-off in REQ takes precedence over a coincident ack
  always_comb begin
    state_nxt = state_q;
    id_nxt    = irq_id;
    ack_edge  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_nxt = REQ;
          id_nxt    = low_id;
        end
      end
      REQ: begin
        if (!mask_q[irq_id]) begin
          state_nxt = IDLE;
        end else if (irq_ack) begin
          state_nxt = SERVICE;
          ack_edge  = 1'b1;
        end
      end
      SERVICE: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending update: level channels mirror the synced line, edge channels set on rise (set beats clear)
  always_comb begin
    mode_nxt = mode_we ? mode_wd : mode_q;
    ack_clr  = (ack_edge && mode_q[irq_id]) ? (NUM_IRQ'(1) << irq_id) : '0;
    sw_clr   = {NUM_IRQ{mode_we}} & ~mode_q & mode_wd;
    pend_nxt = (mode_nxt & (rise | (pending & ~(ack_clr | sw_clr)))) | (~mode_nxt & sync_bit);
  end

  // State, latched id, configuration and pending registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      irq_id  <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      pending <= '0;
    end else begin
      state_q <= state_nxt;
      irq_id  <= id_nxt;
      pending <= pend_nxt;
      mode_q  <= mode_nxt;
      if (mask_we) mask_q <= mask_wd;
    end
  end

  assign irq_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in, mask_wd, mode_wd, pending;
  logic          mask_we, mode_we, irq_ack, eoi, irq_req, busy;
  logic [IW-1:0] irq_id;

  int checks = 0;
  int errors = 0;

  // Reference model state (specification-level view)
  logic [N-1:0] m_pend, m_mask, m_mode, m_prev;
  logic [N-1:0] m_pipe[$];
  int           m_phase;   // 0 idle, 1 requesting, 2 in service
  int           m_id;

  int_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in),
    .mask_we(mask_we), .mask_wd(mask_wd),
    .mode_we(mode_we), .mode_wd(mode_wd),
    .irq_ack(irq_ack), .eoi(eoi),
    .irq_req(irq_req), .irq_id(irq_id), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_mask  = '0;
    m_mode  = '1;
    m_prev  = '0;
    m_phase = 0;
    m_id    = 0;
    m_pipe  = {};
    for (int k = 0; k < S; k++) m_pipe.push_back('0);
  endtask

  // One rising edge of the model, using the inputs the DUT sampled
  task automatic model_edge();
    logic [N-1:0] sy, nxt;
    int           clr_ch, nphase;
    bit           found, emode, sw;
    sy     = m_pipe[0];
    clr_ch = -1;
    nphase = m_phase;
    nxt    = '0;
    if (m_phase == 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && m_pend[i] && m_mask[i]) begin
          found = 1;
          m_id  = i;
        end
      end
      if (found) nphase = 1;
    end else if (m_phase == 1) begin
      if (!m_mask[m_id]) nphase = 0;
      else if (irq_ack) begin
        nphase = 2;
        if (m_mode[m_id]) clr_ch = m_id;
      end
    end else begin
      if (eoi) nphase = 0;
    end
    for (int i = 0; i < N; i++) begin
      emode = mode_we ? mode_wd[i] : m_mode[i];
      sw    = mode_we && !m_mode[i] && mode_wd[i];
      if (!emode) nxt[i] = sy[i];
      else nxt[i] = (sy[i] && !m_prev[i]) || (m_pend[i] && (i != clr_ch) && !sw);
    end
    m_pend = nxt;
    if (mask_we) m_mask = mask_wd;
    if (mode_we) m_mode = mode_wd;
    m_prev = sy;
    void'(m_pipe.pop_front());
    m_pipe.push_back(irq_in);
    m_phase = nphase;
  endtask

  // Advance one clock and compare every output against the model at the falling edge
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    else model_reset();
    @(negedge clk);
    chk("irq_req", 32'(irq_req), 32'(m_phase == 1));
    chk("busy",    32'(busy),    32'(m_phase != 0));
    chk("irq_id",  32'(irq_id),  32'(m_id));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic wait_req(input int max_cyc);
    int n;
    n = 0;
    while (!irq_req && n < max_cyc) begin
      step();
      n++;
    end
    chk("wait_req", 32'(irq_req), 32'd1);
  endtask

  task automatic ack_eoi();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    eoi     = 1'b1; step(); eoi     = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_wd = v; mask_we = 1'b1; step(); mask_we = 1'b0;
  endtask

  task automatic write_mode(input logic [N-1:0] v);
    mode_wd = v; mode_we = 1'b1; step(); mode_we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq_in = v; step(); irq_in = '0;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wd = '0; mode_we = 1'b0; mode_wd = '0;
    irq_ack = 1'b0; eoi = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b1;
    step();

    // Single edge interrupt with exact latency
    write_mask(4'hF);
    pulse(4'b0100);
    step(); chk("lat_e2", 32'(irq_req), 32'd0);
    step(); chk("lat_e3", 32'(irq_req), 32'd0);
    step(); chk("lat_e4_req", 32'(irq_req), 32'd1);
    chk("lat_e4_id", 32'(irq_id), 32'd2);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("ack_pend", 32'(pending), 32'd0);
    chk("ack_req_drop", 32'(irq_req), 32'd0);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("eoi_busy", 32'(busy), 32'd0);

    // Priority order across simultaneous pulses
    pulse(4'b1111);
    for (int k = 0; k < N; k++) begin
      wait_req(10);
      chk("prio_id", 32'(irq_id), 32'(k));
      ack_eoi();
    end
    repeat (3) step();
    chk("prio_pend", 32'(pending), 32'd0);
    chk("prio_idle", 32'(irq_req), 32'd0);

    // Level mode re-requests while held, stops once dropped
    write_mode(4'b1101);
    irq_in = 4'b0010;
    wait_req(10);
    chk("lvl_id1", 32'(irq_id), 32'd1);
    ack_eoi();
    wait_req(10);
    chk("lvl_id2", 32'(irq_id), 32'd1);
    irq_in = '0;
    repeat (4) step();
    ack_eoi();
    repeat (6) step();
    chk("lvl_quiet", 32'(irq_req), 32'd0);
    write_mode(4'hF);

    // Masked channel latches, unmask raises request one cycle after the write
    write_mask(4'h0);
    pulse(4'b1000);
    repeat (4) step();
    chk("mask_pend", 32'(pending), 32'h8);
    chk("mask_noreq", 32'(irq_req), 32'd0);
    write_mask(4'b1000);
    step();
    chk("unmask_req", 32'(irq_req), 32'd1);
    chk("unmask_id", 32'(irq_id), 32'd3);
    ack_eoi();

    // New edge landing on the ack cycle keeps the pending bit set
    write_mask(4'hF);
    pulse(4'b0001);
    wait_req(10);
    chk("sim_id", 32'(irq_id), 32'd0);
    pulse(4'b0001);
    step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("sim_pend0", 32'(pending[0]), 32'd1);
    eoi = 1'b1; step(); eoi = 1'b0;
    wait_req(10);
    chk("sim_again", 32'(irq_id), 32'd0);
    ack_eoi();

    // Reset while in service
    pulse(4'b0100);
    wait_req(10);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("svc_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    model_reset();
    step(); step();
    rst = 1'b1;
    pulse(4'b0010);
    repeat (5) step();
    chk("post_rst_pend", 32'(pending), 32'h2);
    chk("post_rst_noreq", 32'(irq_req), 32'd0);
    write_mask(4'hF);
    wait_req(10);
    chk("post_rst_id", 32'(irq_id), 32'd1);
    ack_eoi();

    // Randomised traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wd = N'($urandom);
      mode_we = ($urandom_range(0, 15) == 0);
      mode_wd = N'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        chk("rnd_rst_req", 32'(irq_req), 32'd0);
        chk("rnd_rst_busy", 32'(busy), 32'd0);
        model_reset();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
